// File: rtl/clk_rst_checker.sv
// clk_rst_checker: watches an external clock/reset pair from the clk_i domain.
//
// The period of mon_clk_i is measured in clk_i cycles and checked against
// [MinPeriod, MaxPeriod]. LockCount consecutive good periods assert locked_o.
// A missing clock (no edge by MaxPeriod+1 cycles) is flagged as an error. The
// length of each mon_rst_ni assertion is measured in mon_clk_i rising edges.
//
// Ports:
//   clk_i          sampling clock
//   rst_ni         synchronous active-low reset
//   mon_clk_i      monitored clock (asynchronous data)
//   mon_rst_ni     monitored active-low reset (asynchronous data)
//   period_o       last measured period, clk_i cycles
//   period_valid_o one-cycle pulse when period_o updates
//   period_err_o   sticky: out-of-range period or clock timeout
//   locked_o       LockCount good periods seen with no error since
//   rst_cycles_o   mon_clk_i edges counted during the last monitored reset
//   rst_done_o     monitored reset released since its last assertion
//   rst_err_o      sticky: a monitored reset was shorter than MinRstCycles
module clk_rst_checker #(
  parameter int unsigned CntWidth     = 16,
  parameter int unsigned MinPeriod    = 4,
  parameter int unsigned MaxPeriod    = 8,
  parameter int unsigned MinRstCycles = 1,
  parameter int unsigned LockCount    = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                mon_clk_i,
  input  logic                mon_rst_ni,
  output logic [CntWidth-1:0] period_o,
  output logic                period_valid_o,
  output logic                period_err_o,
  output logic                locked_o,
  output logic [CntWidth-1:0] rst_cycles_o,
  output logic                rst_done_o,
  output logic                rst_err_o
);

  if (!(MinPeriod <= MaxPeriod && 64'(MaxPeriod) < ((64'd1 << CntWidth) - 64'd1) &&
        LockCount >= 1)) begin : gen_param_check
    $fatal(1, "clk_rst_checker: invalid parameter set");
  end

  localparam int unsigned GoodW = $clog2(LockCount + 1);

  localparam logic [CntWidth-1:0] MinP      = CntWidth'(MinPeriod);
  localparam logic [CntWidth-1:0] MaxP      = CntWidth'(MaxPeriod);
  localparam logic [CntWidth-1:0] TimeoutP  = CntWidth'(MaxPeriod + 1);
  localparam logic [CntWidth-1:0] MinRst    = CntWidth'(MinRstCycles);
  localparam logic [CntWidth-1:0] CntOne    = CntWidth'(1);
  localparam logic [GoodW-1:0]    GoodLast  = GoodW'(LockCount - 1);

  typedef enum logic [1:0] {StIdle, StMeasure, StLocked} state_e;

  state_e              state_q;
  logic [1:0]          clk_sync_q, rst_sync_q;
  logic                clk_hist_q, rst_hist_q;
  logic                edge_q;
  logic [CntWidth-1:0] cnt_q;
  logic [GoodW-1:0]    good_q;
  logic [CntWidth-1:0] rst_cnt_q;
  logic                rst_armed_q;

  logic                in_range;
  logic                rst_fall, rst_rise;
  logic [CntWidth-1:0] rst_cnt_inc;

  assign in_range = (cnt_q >= MinP) && (cnt_q <= MaxP);
  assign rst_fall = rst_hist_q & ~rst_sync_q[1];
  assign rst_rise = rst_sync_q[1] & ~rst_hist_q;
  // Count includes an edge pulse landing in the same cycle as the release.
  assign rst_cnt_inc = (edge_q && rst_cnt_q != '1) ? rst_cnt_q + CntOne : rst_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      clk_sync_q     <= '0;
      rst_sync_q     <= '0;
      clk_hist_q     <= 1'b0;
      rst_hist_q     <= 1'b0;
      edge_q         <= 1'b0;
      cnt_q          <= '0;
      good_q         <= '0;
      rst_cnt_q      <= '0;
      rst_armed_q    <= 1'b0;
      period_o       <= '0;
      period_valid_o <= 1'b0;
      period_err_o   <= 1'b0;
      locked_o       <= 1'b0;
      rst_cycles_o   <= '0;
      rst_done_o     <= 1'b0;
      rst_err_o      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], mon_clk_i};
      rst_sync_q <= {rst_sync_q[0], mon_rst_ni};
      clk_hist_q <= clk_sync_q[1];
      rst_hist_q <= rst_sync_q[1];
      // Registered so the FSM sees the edge three cycles after first sampling high.
      edge_q     <= clk_sync_q[1] & ~clk_hist_q;

      period_valid_o <= 1'b0;

      case (state_q)
        StIdle: begin
          if (edge_q) begin
            state_q <= StMeasure;
            cnt_q   <= CntOne;
          end
        end
        StMeasure, StLocked: begin
          if (edge_q) begin
            period_o       <= cnt_q;
            period_valid_o <= 1'b1;
            cnt_q          <= CntOne;
            if (in_range) begin
              if (state_q == StMeasure) begin
                if (good_q == GoodLast) begin
                  state_q  <= StLocked;
                  locked_o <= 1'b1;
                end
                good_q <= good_q + GoodW'(1);
              end
            end else begin
              period_err_o <= 1'b1;
              locked_o     <= 1'b0;
              good_q       <= '0;
              state_q      <= StMeasure;
            end
          end else if (cnt_q == TimeoutP) begin
            // Clock stopped: drop back and wait for a fresh first edge.
            period_err_o <= 1'b1;
            locked_o     <= 1'b0;
            good_q       <= '0;
            cnt_q        <= '0;
            state_q      <= StIdle;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Only a seen 1->0 arms the reset monitor, so a reset already low when
      // rst_ni releases is not reported.
      if (rst_fall) begin
        rst_cnt_q   <= '0;
        rst_done_o  <= 1'b0;
        rst_armed_q <= 1'b1;
      end else if (rst_armed_q) begin
        if (rst_rise) begin
          rst_cycles_o <= rst_cnt_inc;
          rst_done_o   <= 1'b1;
          rst_armed_q  <= 1'b0;
          if (rst_cnt_inc < MinRst) begin
            rst_err_o <= 1'b1;
          end
        end else begin
          rst_cnt_q <= rst_cnt_inc;
        end
      end
    end
  end

endmodule

// File: doc/clk_rst_checker.md
CLK_RST_CHECKER -- requirements
Module: clk_rst_checker

Interface
- REQ-001: Parameter CntWidth, default 16; width of the period and reset-length counters.
- REQ-002: Parameter MinPeriod, default 4; smallest accepted monitored-clock period, in clk_i cycles.
- REQ-003: Parameter MaxPeriod, default 8; largest accepted period; SHALL satisfy MinPeriod <= MaxPeriod < 2^CntWidth-1 (elaboration $fatal otherwise, non-Verilator).
- REQ-004: Parameter MinRstCycles, default 1; minimum monitored-clock rising edges while the monitored reset is low.
- REQ-005: Parameter LockCount, default 4; consecutive in-range periods required to lock.
- REQ-006: clk_i  input  1  sampling clock; one clock domain.
- REQ-007: rst_ni  input  1  reset, synchronous and active-low.
- REQ-008: mon_clk_i  input  1  monitored clock, treated as asynchronous data.
- REQ-009: mon_rst_ni  input  1  monitored active-low reset, asynchronous data.
- REQ-010: period_o  output  CntWidth  last measured period in clk_i cycles.
- REQ-011: period_valid_o  output  1  one-cycle pulse when period_o updates.
- REQ-012: period_err_o  output  1  sticky: out-of-range period or clock timeout.
- REQ-013: locked_o  output  1  LockCount consecutive good periods seen, no error since.
- REQ-014: rst_cycles_o  output  CntWidth  monitored-clock edges counted during last monitored reset.
- REQ-015: rst_done_o  output  1  monitored reset released since last assertion.
- REQ-016: rst_err_o  output  1  sticky: last reset shorter than MinRstCycles.

Function
- REQ-017: mon_clk_i and mon_rst_ni SHALL each pass a 2-FF synchronizer plus one history register; edge pulses derive from synchronized 0->1 transitions.
- REQ-018: Latency from first clk_i edge sampling mon_clk_i high to internal edge pulse SHALL be 3 cycles.
- REQ-019: FSM states IDLE, MEASURE, LOCKED; reset state IDLE.
- REQ-020: IDLE: on edge -> MEASURE, period counter := 1; no measurement reported.
- REQ-021: MEASURE/LOCKED: counter increments each cycle without edge, saturating at all-ones; on edge, period_o := counter, period_valid_o pulses, counter := 1.
- REQ-022: In range means MinPeriod <= period <= MaxPeriod, both bounds inclusive.
- REQ-023: In-range period in MEASURE increments good count; when it reaches LockCount -> LOCKED, locked_o := 1 same cycle as period_valid_o.
- REQ-024: Out-of-range period: period_err_o := 1, good count := 0, locked_o := 0, state MEASURE.
- REQ-025: Timeout: counter reaches MaxPeriod+1 without edge -> period_err_o := 1, locked_o := 0, good count := 0, state IDLE; an edge in that same cycle takes precedence (normal out-of-range measurement).
- REQ-026: Synchronized mon_rst_ni falling (1->0): reset counter := 0, rst_done_o := 0.
- REQ-027: While synchronized mon_rst_ni low, reset counter increments per mon-clock edge pulse, saturating.
- REQ-028: Synchronized mon_rst_ni rising: rst_cycles_o := counter (including an edge in same cycle), rst_done_o := 1, rst_err_o := 1 if count < MinRstCycles (sticky).
- REQ-029: Period and reset monitoring SHALL be independent; reset activity does not affect FSM.

Reset
- REQ-030: rst_ni low at a clk_i edge SHALL clear all outputs, sticky flags, counters, synchronizers to 0 and FSM to IDLE, at any point including mid-measurement.
- REQ-031: After reset release, a mon_rst_ni already low counts as asserted only after a synchronized 1->0 transition is seen.

Verification
- REQ-032: mon_clk_i period 6 clk_i (3 high/3 low), defaults -> period_valid_o pulses with period_o=6; locked_o=1 at 4th pulse; period_err_o=0.
- REQ-033: Periods 4 and 8 -> accepted, lock; period 3 or 9 -> period_err_o=1 at first measurement, locked_o stays 0.
- REQ-034: Lock at period 6, then hold mon_clk_i low -> period_err_o=1, locked_o=0 when counter hits 9; restart clock -> relock after 4 good periods, period_err_o stays 1.
- REQ-035: mon_rst_ni low across 3 mon_clk_i rising edges -> rst_cycles_o=3, rst_done_o=1, rst_err_o=0; low across 0 edges -> rst_cycles_o=0, rst_err_o=1.
- REQ-036: rst_ni low for 1 cycle while LOCKED -> all outputs 0 next cycle; relock requires first edge plus 4 good periods.
